mips_stage_ex_muldiv: RTL and testbench
=======================================

Name: mips_stage_ex_muldiv

Overview:
- Iterative multiply/divide sequencer for the EX stage. It owns the HI/LO registers and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- The single-cycle ALU datapath cannot compute these operations. This block runs them over multiple cycles and asserts a pipeline stall when a later HI/LO-class op arrives before the result is ready.
- It sits beside the ALU datapath and feeds the EX/MEM pipeline register with MFHI/MFLO read data.

Parameters:
- WIDTH, 32, operand, HI and LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- ctrl  input  control bundle  clock and reset fields. One clock. Reset is synchronous and active-high.
- opValid  input  1  an HI/LO-class op is present in EX this cycle.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- rs  input  WIDTH  first operand; the dividend for DIV/DIVU.
- rt  input  WIDTH  second operand; the divisor for DIV/DIVU.
- flush  input  1  abort the in-flight op and suppress acceptance this cycle.
- stall  output  1  the EX op must be held; upstream keeps opValid/op/rs/rt stable.
- busy  output  1  a multiply or divide is in progress.
- done  output  1  one-cycle pulse in the FIX cycle.
- readData  output  WIDTH  HI for MFHI, LO for MFLO, otherwise 0. Combinational.
- hi  output  WIDTH  current HI register.
- lo  output  WIDTH  current LO register.

Behaviour:
- Reset:
  - state=IDLE, HI=LO=0, counter=0.
  - busy=stall=done=0, readData=0.
  - Reset has priority over flush and over acceptance.
- States:
  - IDLE -> RUN on accepting MULT/MULTU/DIV/DIVU.
  - RUN holds for WIDTH cycles while the counter decrements from WIDTH-1 to 0, then -> FIX.
  - FIX -> IDLE after one cycle.
- busy = (state != IDLE).
- stall = opValid & busy & ~flush.
- Accept condition: opValid & ~stall & ~flush.
  - MT ops write HI/LO at the edge.
  - MF ops drive readData this cycle.
  - Mul/div ops latch operands and op at the edge.
- Latency:
  - Accept edge is edge 0. RUN occupies cycles 1..WIDTH. FIX is cycle WIDTH+1, during which done=1.
  - HI/LO update at the FIX->IDLE edge and are visible from cycle WIDTH+2 (cycle 34 for WIDTH=32).
- Multiply:
  - Shift-add, one bit per cycle, on operand magnitudes.
  - MULT negates the 2*WIDTH product in FIX when the operand signs differ. MULTU never negates.
  - HI = upper half, LO = lower half.
- Divide:
  - Restoring, one quotient bit per cycle, on magnitudes.
  - DIV in FIX: the quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU): no trap. LO = all ones, HI = latched rs, forced in FIX.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- New op while in FIX: stalls (busy=1) and is accepted the cycle after.
- Back-to-back MULT->MFLO: MFLO stalls WIDTH+1 cycles, then reads the new LO.
- flush:
  - In RUN or FIX, returns to IDLE at the edge. HI/LO are unchanged and done is not asserted.
  - Coincident with a would-be accept, it suppresses the accept.
- Operands are latched, so rs/rt changes after acceptance have no effect.

Decomposition:
- Package mips_muldiv_pkg holds:
  - the op encoding constants (MULDIV_OP_*);
  - the state enum (IDLE, RUN, FIX);
  - the WIDTH default.
- Sub-module mips_muldiv_step is combinational and performs one iteration. Given the op class, accumulator, multiplicand/divisor and shift register, it returns the next accumulator/shift state.

Test Plan:
- Reset mid-RUN (cycle 10 of MULT) -> next cycle state IDLE, HI=LO=0, busy=0, done=0.
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF, then MFHI next cycle:
  - stall high for 33 cycles, done in cycle 33;
  - HI=0xFFFFFFFE, LO=0x00000001;
  - readData=0xFFFFFFFE in cycle 34.
- MULT rs=-3 (0xFFFFFFFD) rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV rs=-7 rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=0x12345678 rt=0 -> LO=0xFFFFFFFF, HI=0x12345678.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTLO 0xA5A5A5A5, then MFLO the next cycle -> readData=0xA5A5A5A5, no stall.
- Issue MULT, assert flush at cycle 5 -> busy drops the next cycle, done never pulses, HI/LO keep their prior values.
- MTHI held in EX during FIX -> stall=1 for that cycle, HI written at the following edge, final HI equals the MTHI value rather than the product.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// op encodings, sequencer states, the control bundle and op-class helpers.
package mips_muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [2:0] MULDIV_OP_MULT  = 3'd0;
  localparam logic [2:0] MULDIV_OP_MULTU = 3'd1;
  localparam logic [2:0] MULDIV_OP_DIV   = 3'd2;
  localparam logic [2:0] MULDIV_OP_DIVU  = 3'd3;
  localparam logic [2:0] MULDIV_OP_MTHI  = 3'd4;
  localparam logic [2:0] MULDIV_OP_MTLO  = 3'd5;
  localparam logic [2:0] MULDIV_OP_MFHI  = 3'd6;
  localparam logic [2:0] MULDIV_OP_MFLO  = 3'd7;

  // IDLE: free for any HI/LO op; RUN: one bit per cycle; FIX: sign fix-up and write-back
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_e;

  // Clock and synchronous active-high reset travel together as one bundle
  typedef struct packed {
    logic clk;
    logic reset;
  } muldiv_ctrl_t;

  // Ops that need the iterative engine
  function automatic logic is_muldiv_op(input logic [2:0] op);
    return (op == MULDIV_OP_MULT) || (op == MULDIV_OP_MULTU) ||
           (op == MULDIV_OP_DIV)  || (op == MULDIV_OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MULDIV_OP_DIV) || (op == MULDIV_OP_DIVU);
  endfunction

  // Ops whose operands are two's-complement and need magnitude conversion
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MULDIV_OP_MULT) || (op == MULDIV_OP_DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the multiply/divide engine, purely combinational.
// Multiply: {acc, shreg} is the partial product; shreg starts as the
// multiplier and its LSB selects whether the multiplicand is added before
// the whole pair shifts right by one.
// Divide: acc is the partial remainder, shreg starts as the dividend and
// fills with quotient bits from the right (restoring division).
module mips_muldiv_step
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] shreg,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] shreg_next
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic           q_bit;

  // The partial remainder always stays below the divisor, so the top bit of
  // the trial subtraction is a clean borrow flag that picks the quotient bit.
  always_comb begin
    add_sum    = {1'b0, acc} + {1'b0, operand};
    trial      = {acc, shreg[WIDTH-1]};
    diff       = trial - {1'b0, operand};
    q_bit      = ~diff[WIDTH];
    acc_next   = acc;
    shreg_next = shreg;
    if (is_div) begin
      acc_next   = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      shreg_next = {shreg[WIDTH-2:0], q_bit};
    end else if (shreg[0]) begin
      {acc_next, shreg_next} = {add_sum, shreg[WIDTH-1:1]};
    end else begin
      {acc_next, shreg_next} = {1'b0, acc, shreg[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_stage_ex_muldiv.sv
// EX-stage HI/LO unit: owns HI and LO, runs MULT/MULTU/DIV/DIVU iteratively
// over WIDTH cycles, serves MTHI/MTLO/MFHI/MFLO, and stalls the pipeline when
// a HI/LO op arrives while the engine is still working.
module mips_stage_ex_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  muldiv_ctrl_t     ctrl,
  input  logic             opValid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] readData,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic clk;
  logic reset;

  muldiv_state_e state;
  muldiv_state_e next_state;

  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] rs_q;
  logic [2:0]       op_q;
  logic             neg_q;
  logic             rem_neg_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             accept;
  logic             start;
  logic             run_last;
  logic             signed_op;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] shreg_next;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  assign clk   = ctrl.clk;
  assign reset = ctrl.reset;

  // Handshake: reset and flush both veto acceptance; a busy engine stalls
  // any HI/LO op, including one that arrives during FIX.
  assign busy     = (state != IDLE);
  assign stall    = opValid & busy & ~flush;
  assign accept   = opValid & ~stall & ~flush & ~reset;
  assign start    = accept & is_muldiv_op(op);
  assign run_last = (counter == '0);
  assign done     = (state == FIX) & ~flush & ~reset;

  assign hi = hi_q;
  assign lo = lo_q;

  mips_muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div     (is_div_op(op_q)),
    .acc        (acc),
    .operand    (operand),
    .shreg      (shreg),
    .acc_next   (acc_next),
    .shreg_next (shreg_next)
  );

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: RUN lasts until the counter has walked down to zero, FIX is a
  // single cycle, and flush abandons whatever is in flight.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          next_state = IDLE;
        end else if (run_last) begin
          next_state = FIX;
        end
      end
      FIX: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand magnitudes; negating the most negative value yields its correct
  // unsigned magnitude, so signed overflow needs no special case.
  always_comb begin
    signed_op = is_signed_op(op);
    rs_mag    = (signed_op && rs[WIDTH-1]) ? (~rs + 1'b1) : rs;
    rt_mag    = (signed_op && rt[WIDTH-1]) ? (~rt + 1'b1) : rt;
  end

  // Fix-up of the raw magnitude result: sign correction, and the forced
  // divide-by-zero result (LO all ones, HI the original dividend).
  always_comb begin
    prod     = {acc, shreg};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div_op(op_q)) begin
      if (div_zero_q) begin
        fix_hi = rs_q;
        fix_lo = '1;
      end else begin
        fix_hi = rem_neg_q ? (~acc + 1'b1) : acc;
        fix_lo = neg_q ? (~shreg + 1'b1) : shreg;
      end
    end
  end

  // Engine datapath: latch operands on acceptance, then iterate once per
  // RUN cycle; later rs/rt changes are ignored because everything is latched.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter    <= '0;
      acc        <= '0;
      shreg      <= '0;
      operand    <= '0;
      rs_q       <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q       <= op;
            rs_q       <= rs;
            counter    <= CNT_W'(WIDTH - 1);
            acc        <= '0;
            neg_q      <= signed_op & (rs[WIDTH-1] ^ rt[WIDTH-1]);
            rem_neg_q  <= signed_op & rs[WIDTH-1];
            div_zero_q <= (rt == '0);
            if (is_div_op(op)) begin
              shreg   <= rs_mag;
              operand <= rt_mag;
            end else begin
              shreg   <= rt_mag;
              operand <= rs_mag;
            end
          end
        end
        RUN: begin
          if (!flush) begin
            acc   <= acc_next;
            shreg <= shreg_next;
            if (!run_last) begin
              counter <= counter - 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // HI/LO: engine result lands at the FIX->IDLE edge unless flushed;
  // MTHI/MTLO write directly when accepted (only possible while idle).
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if ((state == FIX) && !flush) begin
      hi_q <= fix_hi;
      lo_q <= fix_lo;
    end else if (accept && (op == MULDIV_OP_MTHI)) begin
      hi_q <= rs;
    end else if (accept && (op == MULDIV_OP_MTLO)) begin
      lo_q <= rs;
    end
  end

  // MFHI/MFLO read path, only when the read is actually accepted
  always_comb begin
    readData = '0;
    if (accept && (op == MULDIV_OP_MFHI)) begin
      readData = hi_q;
    end else if (accept && (op == MULDIV_OP_MFLO)) begin
      readData = lo_q;
    end
  end

endmodule

// File: tb/tb_mips_stage_ex_muldiv.sv
// Self-checking bench for the EX-stage HI/LO unit. Expected HI/LO pairs are
// queued when a mul/div is issued and compared after each done pulse.
module tb_mips_stage_ex_muldiv;
  import mips_muldiv_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  muldiv_ctrl_t ctrl;
  logic         opValid = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [31:0]  rs = '0;
  logic [31:0]  rt = '0;
  logic         flush = 1'b0;
  logic         stall;
  logic         busy;
  logic         done;
  logic [31:0]  readData;
  logic [31:0]  hi;
  logic [31:0]  lo;

  assign ctrl = '{clk: clk, reset: reset};

  mips_stage_ex_muldiv #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .ctrl     (ctrl),
    .opValid  (opValid),
    .op       (op),
    .rs       (rs),
    .rt       (rt),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .readData (readData),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t scoreboard[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  logic doneSeen = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Reference arithmetic using the simulator's own 64-bit operators
  function automatic logic [63:0] refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sbv;
    longint      q;
    longint      r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    res = '0;
    case (o)
      MULDIV_OP_MULTU: res = {32'b0, a} * {32'b0, b};
      MULDIV_OP_MULT:  res = sa * sbv;
      MULDIV_OP_DIVU: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else        res = {a % b, a / b};
      end
      MULDIV_OP_DIV: begin
        if (b == 0) begin
          res = {a, 32'hFFFFFFFF};
        end else begin
          q   = sa / sbv;
          r   = sa % sbv;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Scoreboard consumer: HI/LO are checked in the cycle after done
  always @(negedge clk) begin : monitor
    exp_t e;
    if (doneSeen) begin
      if (scoreboard.size() == 0) begin
        checkOutput("spurious_done", 32'd1, 32'd0);
      end else begin
        e = scoreboard.pop_front();
        checkOutput({e.tag, "_hi"}, hi, e.hi);
        checkOutput({e.tag, "_lo"}, lo, e.lo);
      end
    end
    doneSeen = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op for a single cycle, optionally queueing its expected result,
  // then scramble rs/rt to show the engine latched them.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input bit expectResult, input string tag);
    logic [63:0] m;
    opValid = 1'b1;
    op      = o;
    rs      = a;
    rt      = b;
    #1;
    checkOutput({tag, "_issue_stall"}, 32'(stall), 32'd0);
    if (expectResult) begin
      m = refModel(o, a, b);
      scoreboard.push_back('{tag, m[63:32], m[31:0]});
    end
    tick();
    opValid = 1'b0;
    rs      = $urandom;
    rt      = $urandom;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [2:0]  dirOp [4];
  logic [31:0] dirA  [4];
  logic [31:0] dirB  [4];
  logic [31:0] dirHi [4];
  logic [31:0] dirLo [4];
  string       dirTag[4];

  initial begin : stimulus
    int         stallCnt;
    int         doneCyc;
    int         readCyc;
    int         n;
    logic [2:0] ro;
    logic [31:0] ra;
    logic [31:0] rb;

    dirOp[0] = MULDIV_OP_MULT; dirA[0] = 32'hFFFFFFFD; dirB[0] = 32'd7;
    dirHi[0] = 32'hFFFFFFFF;   dirLo[0] = 32'hFFFFFFEB; dirTag[0] = "mult_neg";
    dirOp[1] = MULDIV_OP_DIV;  dirA[1] = 32'hFFFFFFF9; dirB[1] = 32'd2;
    dirHi[1] = 32'hFFFFFFFF;   dirLo[1] = 32'hFFFFFFFD; dirTag[1] = "div_neg";
    dirOp[2] = MULDIV_OP_DIVU; dirA[2] = 32'h12345678; dirB[2] = 32'd0;
    dirHi[2] = 32'h12345678;   dirLo[2] = 32'hFFFFFFFF; dirTag[2] = "divu_zero";
    dirOp[3] = MULDIV_OP_DIV;  dirA[3] = 32'h80000000; dirB[3] = 32'hFFFFFFFF;
    dirHi[3] = 32'h00000000;   dirLo[3] = 32'h80000000; dirTag[3] = "div_ovf";

    // Reset: an MFHI held during reset must not be accepted
    reset   = 1'b1;
    opValid = 1'b1;
    op      = MULDIV_OP_MFHI;
    tick();
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    checkOutput("rst_readData", readData, 32'd0);
    opValid = 1'b0;
    reset   = 1'b0;
    tick();

    // MULTU max*max followed immediately by MFHI
    applyStimulus(MULDIV_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "multu_max");
    opValid  = 1'b1;
    op       = MULDIV_OP_MFHI;
    rs       = '0;
    stallCnt = 0;
    doneCyc  = 0;
    readCyc  = 0;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (done) doneCyc = c;
      if (!stall) begin
        readCyc = c;
        checkOutput("mfhi_read", readData, 32'hFFFFFFFE);
        break;
      end
      stallCnt++;
      tick();
    end
    tick();
    opValid = 1'b0;
    checkOutput("mfhi_stall_cycles", 32'(stallCnt), 32'd33);
    checkOutput("multu_done_cycle", 32'(doneCyc), 32'd33);
    checkOutput("mfhi_read_cycle", 32'(readCyc), 32'd34);
    checkOutput("multu_hi", hi, 32'hFFFFFFFE);
    checkOutput("multu_lo", lo, 32'h00000001);

    // Directed signed/boundary cases
    for (int i = 0; i < 4; i++) begin
      applyStimulus(dirOp[i], dirA[i], dirB[i], 1'b1, dirTag[i]);
      waitIdle(dirTag[i]);
      checkOutput({dirTag[i], "_final_hi"}, hi, dirHi[i]);
      checkOutput({dirTag[i], "_final_lo"}, lo, dirLo[i]);
    end

    // Random mul/div, checked against the reference model
    for (int i = 0; i < 6; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 4) rb = '0;
      applyStimulus(ro, ra, rb, 1'b1, $sformatf("rand%0d", i));
      waitIdle($sformatf("rand%0d", i));
    end

    // MTLO then MFLO back-to-back: no stall
    applyStimulus(MULDIV_OP_MTLO, 32'hA5A5A5A5, 32'd0, 1'b0, "mtlo");
    opValid = 1'b1;
    op      = MULDIV_OP_MFLO;
    #1;
    checkOutput("mflo_stall", 32'(stall), 32'd0);
    checkOutput("mflo_read", readData, 32'hA5A5A5A5);
    tick();
    opValid = 1'b0;

    // Known HI/LO, then flush coincident with an MTHI accept
    applyStimulus(MULDIV_OP_MTHI, 32'h11112222, 32'd0, 1'b0, "mthi_pre");
    applyStimulus(MULDIV_OP_MTLO, 32'h33334444, 32'd0, 1'b0, "mtlo_pre");
    opValid = 1'b1;
    op      = MULDIV_OP_MTHI;
    rs      = 32'hDEADBEEF;
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    opValid = 1'b0;
    checkOutput("flush_accept_hi", hi, 32'h11112222);

    // Flush a MULT in cycle 5 of RUN
    applyStimulus(MULDIV_OP_MULT, 32'h00001234, 32'h00005678, 1'b0, "mult_flush");
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_busy", 32'(busy), 32'd0);
    repeat (40) tick();
    checkOutput("flush_hi", hi, 32'h11112222);
    checkOutput("flush_lo", lo, 32'h33334444);

    // MTHI arriving during FIX stalls one cycle and wins over the product
    applyStimulus(MULDIV_OP_MULT, 32'd3, 32'd5, 1'b1, "mult_fix");
    n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    checkOutput("fix_done_seen", 32'(done), 32'd1);
    opValid = 1'b1;
    op      = MULDIV_OP_MTHI;
    rs      = 32'hCAFEF00D;
    #1;
    checkOutput("fix_stall", 32'(stall), 32'd1);
    tick();
    checkOutput("fix_accept_stall", 32'(stall), 32'd0);
    tick();
    opValid = 1'b0;
    checkOutput("fix_mthi_hi", hi, 32'hCAFEF00D);
    checkOutput("fix_mthi_lo", lo, 32'h0000000F);

    // Synchronous reset in cycle 10 of a MULT
    applyStimulus(MULDIV_OP_MULT, 32'd7, 32'd9, 1'b0, "mult_reset");
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_hi", hi, 32'd0);
    checkOutput("midrst_lo", lo, 32'd0);
    repeat (40) tick();
    checkOutput("midrst_hi_later", hi, 32'd0);

    checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
